// File: rtl/uart_rx_frame.sv
// Oversampling 8N1 UART receiver that writes each byte of a fixed-length telemetry frame with its index.
// Optional frame-counter sequence check on byte 0 is enabled by defining SEQ_CHECK_EN.
module uart_rx_frame #(
  parameter int OVS      = 8,
  parameter int BYTES    = 20,
  parameter int GAP_BITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [4:0] addr,
  output logic [7:0] data,
  output logic       we,
  output logic       done,
  output logic       frame_err,
  output logic       pkt_abort,
`ifdef SEQ_CHECK_EN
  output logic       seq_err,
`endif
  output logic       busy
);

  localparam int PW      = $clog2(OVS);
  localparam int GAP_LIM = GAP_BITS * OVS;
  localparam int GW      = $clog2(GAP_LIM + 1);

  localparam logic [PW-1:0] PH_HALF  = PW'(OVS / 2 - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(OVS - 1);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [4:0]    IDX_LAST = 5'(BYTES - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_LIM - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t        state_r;
  logic [1:0]    sync_r;
  logic [PW-1:0] phase_r;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r;
  logic [4:0]    idx_r;
  logic [GW-1:0] gap_r;
  logic          rxs_s;
`ifdef SEQ_CHECK_EN
  logic [7:0]    last_cnt_r;
  logic          seen_r;
`endif

  assign rxs_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous line; idle-high reset value avoids a false start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  // Receive FSM, frame index, gap timer and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      phase_r    <= '0;
      bit_r      <= 3'd0;
      shift_r    <= 8'd0;
      idx_r      <= 5'd0;
      gap_r      <= '0;
      addr       <= 5'd0;
      data       <= 8'd0;
      we         <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      pkt_abort  <= 1'b0;
      busy       <= 1'b0;
`ifdef SEQ_CHECK_EN
      seq_err    <= 1'b0;
      last_cnt_r <= 8'd0;
      seen_r     <= 1'b0;
`endif
    end else begin
      we        <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      pkt_abort <= 1'b0;
`ifdef SEQ_CHECK_EN
      seq_err   <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          // A start edge takes precedence over a coinciding gap timeout.
          if (!rxs_s) begin
            state_r <= START;
            phase_r <= '0;
            busy    <= 1'b1;
            gap_r   <= '0;
          end else if (idx_r == 5'd0) begin
            gap_r <= '0;
          end else if (gap_r == GAP_END) begin
            pkt_abort <= 1'b1;
            idx_r     <= 5'd0;
            gap_r     <= '0;
          end else begin
            gap_r <= gap_r + GAP_ONE;
          end
        end
        START: begin
          if (phase_r == PH_HALF) begin
            phase_r <= '0;
            if (rxs_s) begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              state_r <= DATA;
              bit_r   <= 3'd0;
            end
          end else begin
            phase_r <= phase_r + PH_ONE;
          end
        end
        DATA: begin
          if (phase_r == PH_LAST) begin
            phase_r <= '0;
            shift_r <= {rxs_s, shift_r[7:1]};
            bit_r   <= bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              state_r <= DATA;
            end
          end else begin
            phase_r <= phase_r + PH_ONE;
          end
        end
        STOP: begin
          if (phase_r == PH_LAST) begin
            phase_r <= '0;
            busy    <= 1'b0;
            if (rxs_s) begin
              state_r <= IDLE;
              we      <= 1'b1;
              data    <= shift_r;
              addr    <= idx_r;
              if (idx_r == IDX_LAST) begin
                done  <= 1'b1;
                idx_r <= 5'd0;
              end else begin
                idx_r <= idx_r + 5'd1;
              end
`ifdef SEQ_CHECK_EN
              if (idx_r == 5'd0) begin
                seq_err    <= seen_r && (shift_r != last_cnt_r + 8'd1);
                last_cnt_r <= shift_r;
                seen_r     <= 1'b1;
              end else begin
                seen_r     <= seen_r;
              end
`endif
            end else begin
              state_r   <= BREAK;
              frame_err <= 1'b1;
            end
          end else begin
            phase_r <= phase_r + PH_ONE;
          end
        end
        BREAK: begin
          // Line held low: no re-trigger, but a partial frame still ages out.
          if (rxs_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= BREAK;
          end
          if (idx_r == 5'd0) begin
            gap_r <= '0;
          end else if (gap_r == GAP_END) begin
            pkt_abort <= 1'b1;
            idx_r     <= 5'd0;
            gap_r     <= '0;
          end else begin
            gap_r <= gap_r + GAP_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed self-checking bench for uart_rx_frame (OVS=8, BYTES=20, GAP_BITS=16).
module tb_uart_rx_frame;
  localparam int OVS = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [4:0] addr;
  logic [7:0] data;
  logic       we, done, frame_err, pkt_abort, busy;
`ifdef SEQ_CHECK_EN
  logic       seq_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_frame dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .addr(addr),
    .data(data),
    .we(we),
    .done(done),
    .frame_err(frame_err),
    .pkt_abort(pkt_abort),
`ifdef SEQ_CHECK_EN
    .seq_err(seq_err),
`endif
    .busy(busy)
  );

  // Event log sampled on the falling edge, away from the active edge.
  int         we_cnt = 0, done_cnt = 0, ferr_cnt = 0, abort_cnt = 0, seq_cnt = 0, seq_at = -1;
  logic [4:0] done_addr = 5'd0, seq_addr = 5'd31;
  logic [4:0] log_addr[$];
  logic [7:0] log_data[$];

  always @(negedge clk) begin
`ifdef SEQ_CHECK_EN
    if (seq_err) begin
      seq_cnt++;
      seq_at   = we_cnt;
      seq_addr = addr;
    end
`endif
    if (we) begin
      log_addr.push_back(addr);
      log_data.push_back(data);
      we_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_addr = addr;
    end
    if (frame_err) ferr_cnt++;
    if (pkt_abort) abort_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(OVS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(OVS);
    end
    rx = stop;
    wait_clks(OVS);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, bw, bf, ba;

    // Reset state
    wait_clks(3);
    check("rst_we", we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", addr, 5'd0);
    check("rst_data", data, 8'd0);
    check("rst_pulses", {done, frame_err, pkt_abort}, 3'b000);
    reset = 1'b1;
    wait_clks(4);

    // 1: single byte
    b = we_cnt;
    send_byte(8'h55, 1'b1);
    wait_clks(2);
    check("t1_we_count", we_cnt - b, 1);
    check("t1_data", log_data[b], 8'h55);
    check("t1_addr", log_addr[b], 5'd0);
    check("t1_busy", busy, 1'b0);
    check("t1_errs", ferr_cnt + abort_cnt + done_cnt, 0);

    // 2: full frame back to back (index continues at 1 after test 1, so reset first)
    reset = 1'b0;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(4);
    b = we_cnt;
    for (int i = 0; i < 20; i++) send_byte(8'(i * 10), 1'b1);
    wait_clks(2);
    check("t2_we_count", we_cnt - b, 20);
    for (int i = 0; i < 20; i++) begin
      check("t2_addr", log_addr[b + i], 32'(i));
      check("t2_data", log_data[b + i], 32'(i * 10));
    end
    check("t2_done_count", done_cnt, 1);
    check("t2_done_addr", done_addr, 5'd19);

    // 3: glitch, framing error, line held low
    bw = we_cnt;
    bf = ferr_cnt;
    ba = abort_cnt;
    rx = 1'b0;
    wait_clks(2);
    rx = 1'b1;
    wait_clks(1);
    check("t3_glitch_busy_hi", busy, 1'b1);
    wait_clks(8);
    check("t3_glitch_busy_lo", busy, 1'b0);
    send_byte(8'h3C, 1'b0);
    wait_clks(15 * OVS);
    check("t3_break_busy", busy, 1'b0);
    wait_clks(15 * OVS);
    rx = 1'b1;
    wait_clks(4 * OVS);
    check("t3_we_count", we_cnt - bw, 0);
    check("t3_ferr_count", ferr_cnt - bf, 1);
    check("t3_abort_count", abort_cnt - ba, 0);

    // 4: gap timeout on a partial frame
    b = we_cnt;
    ba = abort_cnt;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    for (int i = 0; i < 5; i++) check("t4_addr", log_addr[b + i], 32'(i));
    wait_clks(15 * OVS);
    check("t4_no_abort_early", abort_cnt - ba, 0);
    wait_clks(2 * OVS);
    check("t4_abort_count", abort_cnt - ba, 1);
    send_byte(8'h66, 1'b1);
    wait_clks(2);
    check("t4_we_count", we_cnt - b, 6);
    check("t4_restart_addr", log_addr[b + 5], 5'd0);
    check("t4_restart_data", log_data[b + 5], 8'h66);

    // 5: reset during bit 4 of byte 7
    b = we_cnt;
    for (int i = 1; i <= 6; i++) send_byte(8'(8'h11 * i), 1'b1);
    wait_clks(2);
    check("t5_pre_addr", log_addr[b + 5], 5'd6);
    rx = 1'b0;
    wait_clks(OVS);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_clks(OVS);
    end
    rx = 1'b1;
    wait_clks(3);
    check("t5_busy_mid", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_addr", addr, 5'd0);
    check("t5_rst_data", data, 8'd0);
    check("t5_rst_pulses", {we, done, frame_err, pkt_abort}, 4'b0000);
    rx = 1'b1;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(4);
    b = we_cnt;
    send_byte(8'hA5, 1'b1);
    wait_clks(2);
    check("t5_we_count", we_cnt - b, 1);
    check("t5_next_addr", log_addr[b], 5'd0);
    check("t5_next_data", log_data[b], 8'hA5);

`ifdef SEQ_CHECK_EN
    // 6: frame counter sequence 7, 8, 10
    reset = 1'b0;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(4);
    b = we_cnt;
    bw = seq_cnt;
    for (int f = 0; f < 3; f++) begin
      send_byte((f == 0) ? 8'd7 : (f == 1) ? 8'd8 : 8'd10, 1'b1);
      for (int i = 1; i < 20; i++) send_byte(8'(i), 1'b1);
    end
    wait_clks(2);
    check("t6_seq_count", seq_cnt - bw, 1);
    check("t6_seq_pos", seq_at - b, 40);
    check("t6_seq_addr", seq_addr, 5'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
